// File: rtl/tohost_monitor_if.sv
// rtl/tohost_monitor_if.sv - data-memory store port observed by the tohost monitor
interface tohost_monitor_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_strb
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data,
        input wr_strb
    );
endinterface

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - tohost store decoder with cycle-budget timeout and sticky verdict
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] TIMEOUT     = 32'd5000
) (
    input  logic              clk,
    input  logic              rst,
    tohost_monitor_if.slave   bus,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              done_pulse,
    output logic [30:0]       fail_code,
    output logic [31:0]       cycles
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [30:0] code_nx;
    logic [31:0] cycles_nx;
    logic [31:0] cycles_inc;
    logic        pulse_nx;
    logic        qualify;

    // A verdict store is a full-word, non-zero write to the lower tohost word.
    assign qualify = bus.wr_en
                  && (bus.wr_addr == TOHOST_ADDR)
                  && (bus.wr_strb == 4'b1111)
                  && (bus.wr_data != 32'd0);

    // Saturating increment keeps the counter pinned once it hits all ones.
    assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

    // Next-state decode; a verdict store takes priority over budget expiry on the same edge.
    always_comb begin
        state_nx  = state;
        code_nx   = fail_code;
        cycles_nx = cycles;
        pulse_nx  = 1'b0;
        if (state == ST_RUN) begin
            cycles_nx = cycles_inc;
            if (qualify) begin
                pulse_nx = 1'b1;
                if (bus.wr_data == 32'd1) begin
                    state_nx = ST_PASS;
                end else begin
                    state_nx = ST_FAIL;
                    // Even non-zero data is not a legal riscv-tests verdict; flag it distinctly.
                    code_nx  = bus.wr_data[0] ? bus.wr_data[31:1] : 31'h7FFF_FFFF;
                end
            end else if (cycles_inc == TIMEOUT) begin
                state_nx = ST_TIMEOUT;
                pulse_nx = 1'b1;
            end
        end
    end

    // State, counter, failure code and entry pulse registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            cycles     <= 32'd0;
            fail_code  <= 31'd0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cycles     <= cycles_nx;
            fail_code  <= code_nx;
            done_pulse <= pulse_nx;
        end
    end

    // Sticky flags are decoded straight from the state register, so nothing reaches them from inputs.
    assign done    = (state != ST_RUN);
    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_tohost_monitor.sv
// tb/tb_tohost_monitor.sv - self-checking bench for tohost_monitor
module tb_tohost_monitor;

    logic clk;
    logic rst;

    tohost_monitor_if bus ();

    logic        a_done, a_pass, a_fail, a_tmo, a_pulse;
    logic [30:0] a_code;
    logic [31:0] a_cyc;
    logic        b_done, b_pass, b_fail, b_tmo, b_pulse;
    logic [30:0] b_code;
    logic [31:0] b_cyc;

    tohost_monitor #(.TOHOST_ADDR(32'h0000_1000), .TIMEOUT(32'd100)) dut_a (
        .clk(clk), .rst(rst), .bus(bus),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tmo),
        .done_pulse(a_pulse), .fail_code(a_code), .cycles(a_cyc)
    );

    tohost_monitor #(.TOHOST_ADDR(32'h0000_1000), .TIMEOUT(32'd50)) dut_b (
        .clk(clk), .rst(rst), .bus(bus),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tmo),
        .done_pulse(b_pulse), .fail_code(b_code), .cycles(b_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    logic        s_en   [0:255];
    logic [31:0] s_addr [0:255];
    logic [31:0] s_data [0:255];
    logic [3:0]  s_strb [0:255];

    typedef struct {
        logic        done, pass, fail, tmo, pulse;
        logic [30:0] code;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        e_pass;
        logic        e_fail;
        logic [30:0] e_code;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fa();
        return {27'd0, a_done, a_pass, a_fail, a_tmo, a_pulse};
    endfunction

    function automatic logic [31:0] fb();
        return {27'd0, b_done, b_pass, b_fail, b_tmo, b_pulse};
    endfunction

    function automatic logic [31:0] ff(input logic d, input logic p, input logic f, input logic t, input logic u);
        return {27'd0, d, p, f, t, u};
    endfunction

    // Verdict from the recorded store history: first qualifying store wins, else the budget edge.
    function automatic exp_t model(input int n, input int t);
        exp_t e;
        int   vk;
        vk = 0;
        e  = '{default: '0};
        for (int k = 1; k <= n; k++) begin
            if (vk == 0) begin
                if (s_en[k] && s_addr[k] == 32'h1000 && s_strb[k] == 4'hF && s_data[k] != 32'd0) begin
                    vk = k;
                    e.done = 1'b1;
                    if (s_data[k] == 32'd1) begin
                        e.pass = 1'b1;
                    end else begin
                        e.fail = 1'b1;
                        e.code = s_data[k][0] ? s_data[k][31:1] : 31'h7FFF_FFFF;
                    end
                end else if (k == t) begin
                    vk = k;
                    e.done = 1'b1;
                    e.tmo  = 1'b1;
                end
            end
        end
        e.cyc   = (vk == 0) ? 32'(n) : 32'(vk);
        e.pulse = (vk != 0) && (vk == n);
        return e;
    endfunction

    // One rising edge with the given store presented; called and returns with clk low.
    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        edge_cnt++;
        s_en[edge_cnt]   = en;
        s_addr[edge_cnt] = a;
        s_data[edge_cnt] = d;
        s_strb[edge_cnt] = s;
        bus.wr_en   = en;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_strb = s;
        @(posedge clk);
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.wr_addr = 32'd0;
        bus.wr_data = 32'd0;
        bus.wr_strb = 4'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Assert reset between edges, verify the asynchronous clear, release before the next edge.
    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #2;
        chk({tag, "_rst_a_flags"}, fa(), 32'd0);
        chk({tag, "_rst_a_cycles"}, a_cyc, 32'd0);
        chk({tag, "_rst_a_code"}, {1'b0, a_code}, 32'd0);
        chk({tag, "_rst_b_flags"}, fb(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        edge_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            s_en[i] = 1'b0;
            s_addr[i] = 32'd0;
            s_data[i] = 32'd0;
            s_strb[i] = 4'd0;
        end
    endtask

    task automatic cmp_model(input string tag);
        exp_t ea, eb;
        ea = model(edge_cnt, 100);
        eb = model(edge_cnt, 50);
        chk({tag, "_a_flags"}, fa(), ff(ea.done, ea.pass, ea.fail, ea.tmo, ea.pulse));
        chk({tag, "_a_code"}, {1'b0, a_code}, {1'b0, ea.code});
        chk({tag, "_a_cycles"}, a_cyc, ea.cyc);
        chk({tag, "_b_flags"}, fb(), ff(eb.done, eb.pass, eb.fail, eb.tmo, eb.pulse));
        chk({tag, "_b_code"}, {1'b0, b_code}, {1'b0, eb.code});
        chk({tag, "_b_cycles"}, b_cyc, eb.cyc);
    endtask

    initial begin
        logic        en;
        logic [31:0] ad, da;
        logic [3:0]  sb;
        int          len, thr, sel;

        rst = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 32'd0;
        bus.wr_data = 32'd0;
        bus.wr_strb = 4'd0;

        vt[0] = '{20,  32'h1000, 32'h0000_0001, 4'hF, 1'b1, 1'b0, 31'h0};
        vt[1] = '{5,   32'h1000, 32'h0000_0007, 4'hF, 1'b0, 1'b1, 31'h3};
        vt[2] = '{8,   32'h1000, 32'h0000_0006, 4'hF, 1'b0, 1'b1, 31'h7FFF_FFFF};
        vt[3] = '{10,  32'h1000, 32'h0000_0000, 4'hF, 1'b0, 1'b0, 31'h0};
        vt[4] = '{11,  32'h1000, 32'h0000_0001, 4'h3, 1'b0, 1'b0, 31'h0};
        vt[5] = '{12,  32'h1004, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 31'h0};
        vt[6] = '{3,   32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 31'h7FFF_FFFF};
        vt[7] = '{2,   32'h1000, 32'h8000_0000, 4'hF, 1'b0, 1'b1, 31'h7FFF_FFFF};
        vt[8] = '{7,   32'h1001, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 31'h0};
        vt[9] = '{100, 32'h1000, 32'h0000_0003, 4'hF, 1'b0, 1'b1, 31'h1};

        // Single-store vectors on the 100-cycle instance.
        for (int r = 0; r < 10; r++) begin
            apply_reset("vec");
            idle(vt[r].k - 1);
            step(1'b1, vt[r].addr, vt[r].data, vt[r].strb);
            chk($sformatf("vec%0d_flags", r), fa(),
                ff(vt[r].e_pass | vt[r].e_fail, vt[r].e_pass, vt[r].e_fail, 1'b0, vt[r].e_pass | vt[r].e_fail));
            chk($sformatf("vec%0d_code", r), {1'b0, a_code}, {1'b0, vt[r].e_code});
            chk($sformatf("vec%0d_cycles", r), a_cyc, 32'(vt[r].k));
        end

        // Pass at edge 20: one-cycle pulse, cycles frozen afterwards.
        apply_reset("pass20");
        idle(19);
        step(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("pass20_flags", fa(), ff(1, 1, 0, 0, 1));
        chk("pass20_cycles", a_cyc, 32'd20);
        step(1'b0, 32'd0, 32'd0, 4'd0);
        chk("pass20_pulse_gone", fa(), ff(1, 1, 0, 0, 0));
        idle(39);
        chk("pass20_cycles_e60", a_cyc, 32'd20);
        chk("pass20_flags_e60", fa(), ff(1, 1, 0, 0, 0));

        // Ignored stores then budget expiry.
        apply_reset("tmo");
        idle(9);
        step(1'b1, 32'h1000, 32'h0, 4'hF);
        step(1'b1, 32'h1000, 32'h1, 4'h3);
        step(1'b1, 32'h1004, 32'h1, 4'hF);
        idle(87);
        chk("tmo_run_e99", fa(), 32'd0);
        chk("tmo_cycles_e99", a_cyc, 32'd99);
        step(1'b0, 32'd0, 32'd0, 4'd0);
        chk("tmo_flags_e100", fa(), ff(1, 0, 0, 1, 1));
        chk("tmo_cycles_e100", a_cyc, 32'd100);
        chk("tmo_code_e100", {1'b0, a_code}, 32'd0);
        chk("tmo_b_flags", fb(), ff(1, 0, 0, 1, 0));
        chk("tmo_b_cycles", b_cyc, 32'd50);
        step(1'b0, 32'd0, 32'd0, 4'd0);
        chk("tmo_pulse_gone", fa(), ff(1, 0, 0, 1, 0));

        // Store on the exact budget edge beats the timeout; later stores ignored.
        apply_reset("edge50");
        idle(49);
        step(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("edge50_b_flags", fb(), ff(1, 1, 0, 0, 1));
        chk("edge50_b_cycles", b_cyc, 32'd50);
        idle(4);
        step(1'b1, 32'h1000, 32'h3, 4'hF);
        chk("edge55_b_flags", fb(), ff(1, 1, 0, 0, 0));
        chk("edge55_b_code", {1'b0, b_code}, 32'd0);
        chk("edge55_b_cycles", b_cyc, 32'd50);

        // Mid-run reset after a pass, then a fresh pass at edge 4.
        apply_reset("mid");
        idle(9);
        step(1'b1, 32'h1000, 32'h1, 4'hF);
        idle(20);
        chk("mid_pre_pass", fa(), ff(1, 1, 0, 0, 0));
        apply_reset("mid30");
        idle(3);
        step(1'b1, 32'h1000, 32'h1, 4'hF);
        chk("mid_e4_flags", fa(), ff(1, 1, 0, 0, 1));
        chk("mid_e4_cycles", a_cyc, 32'd4);

        // Randomized store streams against the history-based model.
        for (int r = 0; r < 12; r++) begin
            apply_reset("rnd");
            len = $urandom_range(40, 130);
            thr = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 3 : 12);
            for (int e = 0; e < len; e++) begin
                en  = 1'($urandom % 2);
                ad  = ($urandom_range(0, 99) < thr) ? 32'h1000
                    : (($urandom % 3 == 0) ? 32'h1004 : $urandom);
                sb  = ($urandom % 2 == 1) ? 4'hF : 4'($urandom);
                sel = $urandom_range(0, 4);
                case (sel)
                    0:       da = 32'd0;
                    1:       da = 32'd1;
                    2:       da = $urandom | 32'd1;
                    3:       da = $urandom & ~32'd1;
                    default: da = $urandom;
                endcase
                step(en, ad, da, sb);
                cmp_model($sformatf("rnd%0d_e%0d", r, edge_cnt));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
